fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 16-bit five-stage pipelined CPU. Owns the program counter. Drives the instruction-memory read port and loads the IF/ID pipeline register that feeds decode/control. Applies stall and branch-redirect requests from later stages, and drains the pipeline before asserting the global halt when a halt instruction is fetched.

## Interface
Parameters:
- `PC_W`, 16, program-counter and address width.
- `RESET_PC`, 16'h0000, PC value after reset.
- `HLT_OPCODE`, 4'hF, value of `instr[15:12]` that marks a halt instruction.
- `NOP_INSTR`, 16'h0000, instruction word inserted as a bubble.
- `DRAIN_CYCLES`, 4, number of non-stalled edges from HLT capture until `hlt` rises (ID, EX, MEM, WB).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard unit requests that PC and IF/ID hold.
- `br_taken` in 1: resolved taken branch or jump; redirect and squash.
- `br_target` in PC_W: redirect address, valid when `br_taken` is high.
- `im_addr` out PC_W: instruction-memory address; equals `pc`.
- `im_rd_en` out 1: instruction-memory read enable.
- `im_instr` in 16: instruction word, combinational read of `im_addr`.
- `pc` out PC_W: current fetch PC.
- `if_id_instr` out 16: IF/ID instruction.
- `if_id_pc1` out PC_W: IF/ID PC+1, used for branch target computation downstream.
- `if_id_valid` out 1: IF/ID holds a real instruction (0 means bubble).
- `hlt` out 1: pipeline drained after a halt; sticky until reset.

## Operation
- Addressing is by word. The sequential next PC is `pc + 1`, computed modulo 2^PC_W, so 16'hFFFF wraps to 16'h0000.
- The state machine has three states: RUN, DRAIN, HALTED.
- Edge priority, highest first: reset, HALTED, `br_taken`, `stall`, normal.
- HALTED: all inputs are ignored. PC and IF/ID hold. `im_rd_en`=0 and `hlt`=1.
- `br_taken` in RUN or DRAIN:
  - `pc` loads `br_target`.
  - IF/ID loads a bubble (`NOP_INSTR`, valid=0, pc1 = 0).
  - State goes to RUN and the drain counter clears.
  - `br_taken` wins over a simultaneous `stall`.
- `stall` (no `br_taken`): `pc`, IF/ID, state and drain counter all hold.
- RUN, normal edge:
  - IF/ID loads `im_instr`, `pc+1` and valid=1.
  - If `im_instr[15:12]==HLT_OPCODE`: `pc` holds, state goes to DRAIN, counter is set to 0.
  - Otherwise `pc` loads `pc+1`.
- DRAIN, normal edge:
  - IF/ID loads a bubble and `pc` holds.
  - If counter == DRAIN_CYCLES-1, go to HALTED and set `hlt`=1. Otherwise increment the counter.
- `im_rd_en` = 1 only in RUN. It is combinational from the state.
- A halt fetched on a wrong path is cancelled by a later `br_taken`. No `hlt` is produced and fetch resumes at the target.
- The counter width is $clog2(DRAIN_CYCLES) bits, minimum 1.

## Timing
- Reset values:
  - `pc`=RESET_PC
  - `if_id_instr`=NOP_INSTR, `if_id_pc1`=0, `if_id_valid`=0
  - `hlt`=0
  - state=RUN, counter=0
  - `im_rd_en`=1 while in reset.
- Reset asserted in any state, DRAIN and HALTED included, returns immediately and asynchronously to the values above.
- Fetch latency: an instruction at address A, presented in cycle N, appears on IF/ID after edge N.
- Redirect penalty: one bubble. The target instruction reaches IF/ID on the edge after `br_taken` is sampled.
- Halt: if HLT is captured at edge E0 with no stalls, `hlt` rises at E0+DRAIN_CYCLES. Each stalled edge in DRAIN adds one cycle.
- `pc`, `hlt` and all `if_id_*` outputs are registered. `im_addr` and `im_rd_en` come from registered state only, so there is no path from `im_instr` to `im_addr`.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants, including HLT_OPCODE
  - NOP_INSTR
  - PC_W / instruction width
  - the fetch state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2)
- One sub-module, `halt_ctrl`, holds the RUN/DRAIN/HALTED FSM and the drain counter.
  - Inputs: `is_hlt`, `stall`, `br_taken`.
  - Outputs: `state`, `hlt`.
- PC and IF/ID registers stay in `fetch_stage`.

## Test plan
- Reset then free run, IM holding sequential non-HLT words: `pc` reads 0,1,2,3 on successive edges and `if_id_pc1` lags `pc` by 0 after each edge; `if_id_valid`=1 from the first edge.
- `stall` held 2 cycles at `pc`=5: `pc` stays 5 and IF/ID stays unchanged for 2 edges, then `pc` goes to 6.
- `br_taken`=1 with `br_target`=16'h0040 and `stall`=1 in the same cycle: next `pc`=16'h0040 and `if_id_valid`=0. The following edge gives `if_id_instr`=IM[0x40].
- HLT word (16'hF000) at address 3, no stalls:
  - `pc` holds at 3 and `im_rd_en` drops after the capture edge.
  - 4 bubbles follow; `hlt`=1 exactly 4 edges after capture.
  - `hlt` stays 1 and ignores a later `br_taken`.
- HLT captured, then `br_taken` with target 16'h0010 two edges later: state returns to RUN, `hlt` never asserts, fetch resumes at 16'h0010.
- Wrap-around and reset in DRAIN:
  - `pc`=16'hFFFF steps to 16'h0000.
  - `rst_n` pulsed low mid-DRAIN: `hlt`=0, `pc`=RESET_PC and `if_id_valid`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage CPU: widths, opcodes, bubble
// word and the fetch-stage state encoding.
package cpu_pkg;

    localparam int PC_W     = 16;
    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_LW  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_SW  = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam logic [OPCODE_W-1:0] HLT_OPCODE = OP_HLT;
    localparam logic [INSTR_W-1:0]  NOP_INSTR  = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the
// instruction memory (slave); the memory answers combinationally.
interface fetch_stage_if #(
    parameter int PC_W = cpu_pkg::PC_W
) ();

    logic [PC_W-1:0]             im_addr;
    logic                        im_rd_en;
    logic [cpu_pkg::INSTR_W-1:0] im_instr;

    modport master (output im_addr, output im_rd_en, input im_instr);
    modport slave  (input im_addr, input im_rd_en, output im_instr);

endinterface

// File: rtl/fetch_stage_halt_ctrl.sv
// RUN/DRAIN/HALTED controller: after a halt is fetched, waits for the older
// instructions to leave the pipe, then raises a sticky hlt.
module halt_ctrl #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_hlt,
    input  logic                  stall,
    input  logic                  br_taken,
    output cpu_pkg::fetch_state_e state,
    output logic                  hlt
);
    import cpu_pkg::*;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hlt_q, hlt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            hlt_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking for all state so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hlt_q   <= hlt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first; every path assigns every _d, so no latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        hlt_d   = hlt_q;

        unique case (state_q)
            ST_HALTED: ;
            ST_RUN, ST_DRAIN: begin
                if (br_taken) begin
                    // A redirect proves the halt was on a wrong path.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (!stall) begin
                    if (state_q == ST_RUN) begin
                        if (is_hlt) begin
                            state_d = ST_DRAIN;
                            cnt_d   = '0;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HALTED;
                        hlt_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign state = state_q;
    assign hlt   = hlt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory port and
// loads IF/ID, honouring stall, branch redirect and halt drain.
module fetch_stage #(
    parameter int                          PC_W         = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0]             RESET_PC     = '0,
    parameter logic [cpu_pkg::OPCODE_W-1:0] HLT_OPCODE  = cpu_pkg::HLT_OPCODE,
    parameter logic [cpu_pkg::INSTR_W-1:0] NOP_INSTR    = cpu_pkg::NOP_INSTR,
    parameter int                          DRAIN_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        br_taken,
    input  logic [PC_W-1:0]             br_target,
    fetch_stage_if.master               im,
    output logic [PC_W-1:0]             pc,
    output logic [cpu_pkg::INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]             if_id_pc1,
    output logic                        if_id_valid,
    output logic                        hlt
);
    import cpu_pkg::*;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc1;
        logic               valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc1: '0, valid: 1'b0};

    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    if_id_t          if_id_q, if_id_d;
    fetch_state_e    state;
    logic            is_hlt;

    assign pc_inc = pc_q + 1'b1;
    assign is_hlt = (opcode_of(im.im_instr) == HLT_OPCODE);

    halt_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .is_hlt   (is_hlt),
        .stall    (stall),
        .br_taken (br_taken),
        .state    (state),
        .hlt      (hlt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            if_id_q <= BUBBLE;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;

        unique case (state)
            ST_HALTED: ;
            ST_RUN, ST_DRAIN: begin
                if (br_taken) begin
                    pc_d    = br_target;
                    if_id_d = BUBBLE;
                end else if (!stall) begin
                    if (state == ST_RUN) begin
                        if_id_d = '{instr: im.im_instr, pc1: pc_inc, valid: 1'b1};
                        // The halt word parks the PC on itself while the pipe drains.
                        if (!is_hlt) pc_d = pc_inc;
                    end else begin
                        if_id_d = BUBBLE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Address and enable depend on registered state only, never on im_instr.
    assign im.im_addr   = pc_q;
    assign im.im_rd_en  = (state == ST_RUN);

    assign pc          = pc_q;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc1   = if_id_q.pc1;
    assign if_id_valid = if_id_q.valid;

endmodule
